// File: rtl/tile_shading_pkg.sv
// Shared tile-shading constants and the light-list emitter state encoding.
package tile_shading_pkg;

    localparam int NTX        = 120;
    localparam int NTY        = 68;
    localparam int MAX_LIGHTS = 32;
    localparam int LIGHT_ID_W = $clog2(MAX_LIGHTS);
    localparam int TILE_IDX_W = $clog2(NTX * NTY);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        EMIT,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/tile_lsb_encoder.sv
// Lowest-set-bit encoder: index of the lowest set mask bit, plus an any-bit flag.
module tile_lsb_encoder
    import tile_shading_pkg::*;
#(
    parameter int W     = MAX_LIGHTS,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     mask,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Scan from the top down so the last hit wins, leaving the lowest set bit.
    always_comb begin
        index = '0;
        any   = |mask;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/tile_light_list_emitter.sv
// Walks every tile, reads its light mask from RAM and emits one entry per set
// light (ascending ids, ascending tiles) over a valid/ready stream.
// Build option TILE_LIGHT_SKIP_EMPTY_EN: when defined, empty tiles emit nothing;
// otherwise an empty tile emits a single entry flagged out_empty/out_last.
module tile_light_list_emitter #(
    parameter int NTX        = tile_shading_pkg::NTX,
    parameter int NTY        = tile_shading_pkg::NTY,
    parameter int MAX_LIGHTS = tile_shading_pkg::MAX_LIGHTS,
    parameter int TILE_IDX_W = $clog2(NTX * NTY)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          mask_rd_en,
    output logic [TILE_IDX_W-1:0]         mask_rd_addr,
    input  logic [MAX_LIGHTS-1:0]         mask_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TILE_IDX_W-1:0]         out_tile,
    output logic [$clog2(MAX_LIGHTS)-1:0] out_light_id,
    output logic                          out_last,
    output logic                          out_empty
);

    import tile_shading_pkg::*;

    localparam int                    LID_W     = $clog2(MAX_LIGHTS);
    localparam logic [TILE_IDX_W-1:0] LAST_TILE = TILE_IDX_W'(NTX * NTY - 1);

    state_t                  state_q;
    logic [TILE_IDX_W-1:0]   tile_q;
    logic [MAX_LIGHTS-1:0]   pending_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rd_en_q;
    logic [TILE_IDX_W-1:0]   rd_addr_q;

    logic [LID_W-1:0]        lsb_idx;
    logic                    pend_any;
    logic [MAX_LIGHTS-1:0]   lsb_onehot;
    logic                    one_left;
    logic                    emit_vld;
    logic [TILE_IDX_W-1:0]   tile_d;

    tile_lsb_encoder #(
        .W     (MAX_LIGHTS),
        .IDX_W (LID_W)
    ) u_lsb (
        .mask  (pending_q),
        .index (lsb_idx),
        .any   (pend_any)
    );

    // Isolate the lowest pending bit; it is the last one when nothing else remains.
    always_comb begin
        lsb_onehot = pending_q & (~pending_q + MAX_LIGHTS'(1));
        one_left   = (pending_q == lsb_onehot);
        tile_d     = tile_q + TILE_IDX_W'(1);
`ifdef TILE_LIGHT_SKIP_EMPTY_EN
        emit_vld   = (state_q == EMIT) && pend_any;
`else
        emit_vld   = (state_q == EMIT);
`endif
    end

    // Stream outputs decode only registered state, so they hold during stalls.
    assign out_valid    = emit_vld;
    assign out_tile     = tile_q;
    assign out_light_id = (emit_vld && pend_any) ? lsb_idx : '0;
    assign out_last     = emit_vld && one_left;
    assign out_empty    = emit_vld && !pend_any;

    assign busy         = busy_q;
    assign done         = done_q;
    assign mask_rd_en   = rd_en_q;
    assign mask_rd_addr = rd_addr_q;

    // Pass sequencer: read each tile's mask, drain its bits, step to the next tile.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tile_q    <= '0;
            pending_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tile_q    <= '0;
                        rd_addr_q <= '0;
                        rd_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= READ;
                    end
                end
                READ: state_q <= WAIT;
                WAIT: begin
                    pending_q <= mask_rd_data;
                    state_q   <= EMIT;
                end
                EMIT: begin
                    if (!pend_any) begin
`ifdef TILE_LIGHT_SKIP_EMPTY_EN
                        state_q <= NEXT;
`else
                        if (out_ready) state_q <= NEXT;
`endif
                    end else if (out_ready) begin
                        pending_q <= pending_q & ~lsb_onehot;
                        if (one_left) state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (tile_q == LAST_TILE) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tile_q    <= tile_d;
                        rd_addr_q <= tile_d;
                        rd_en_q   <= 1'b1;
                        state_q   <= READ;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tile_light_list_emitter.md
TILE_LIGHT_LIST_EMITTER -- requirements
Module: tile_light_list_emitter

Interface
REQ-001 SHALL have parameter NTX, default 120: tiles per row.
REQ-002 SHALL have parameter NTY, default 68: tiles per column.
REQ-003 SHALL have parameter MAX_LIGHTS, default 32: width of the per-tile light mask.
REQ-004 SHALL have parameter TILE_IDX_W, default $clog2(NTX*NTY): width of the tile index.
REQ-005 SHALL have the following ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins a full pass over all tiles.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a pass.
- mask_rd_en  out  1  tile-mask RAM read strobe.
- mask_rd_addr  out  TILE_IDX_W  tile index being read.
- mask_rd_data  in  MAX_LIGHTS  mask; valid exactly 1 cycle after mask_rd_en.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accept.
- out_tile  out  TILE_IDX_W  tile index of the entry.
- out_light_id  out  $clog2(MAX_LIGHTS)  light id.
- out_last  out  1  last entry for this tile.
- out_empty  out  1  entry marks a tile with no lights.

Function
REQ-006 SHALL implement states IDLE, READ, WAIT, EMIT, NEXT, DONE.
REQ-007 IDLE: on start, SHALL set tile=0 and go to READ; start SHALL be ignored in every other state.
REQ-008 READ: SHALL assert mask_rd_en for one cycle with mask_rd_addr=tile, then go to WAIT.
REQ-009 WAIT: SHALL latch mask_rd_data into a pending register, then go to EMIT.
REQ-010 EMIT, pending non-zero: SHALL drive out_valid=1 and out_light_id=index of the lowest set pending bit.
REQ-011 EMIT, pending non-zero: SHALL drive out_tile=tile and out_empty=0.
REQ-012 EMIT: SHALL drive out_last=1 exactly when one pending bit remains.
REQ-013 An entry SHALL transfer only on a cycle with out_valid&&out_ready; the transfer SHALL clear the emitted bit in pending.
REQ-014 Throughput SHALL be one entry per cycle while out_ready is held high.
REQ-015 All out_* signals SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 When the final bit of a tile transfers, the block SHALL go to NEXT.
REQ-017 NEXT: if tile==NTX*NTY-1, SHALL go to DONE; otherwise SHALL increment tile and go to READ.
REQ-018 DONE: SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-019 The empty-tile case (pending==0 in EMIT) SHALL follow REQ-026.
REQ-020 Light ids SHALL be emitted in strictly ascending order within a tile.
REQ-021 Tiles SHALL be emitted in ascending index order.

Reset
REQ-022 While rst_n=0, the block SHALL force IDLE, tile=0 and pending=0.
REQ-023 While rst_n=0, the block SHALL drive busy, done, mask_rd_en, out_valid, out_last and out_empty to 0.
REQ-024 While rst_n=0, the block SHALL drive mask_rd_addr, out_tile and out_light_id to 0.
REQ-025 Reset asserted mid-pass SHALL abort the pass with no done pulse; the next start SHALL restart the pass at tile 0.

Configuration
REQ-026 Macro TILE_LIGHT_SKIP_EMPTY_EN:
- Defined: an empty tile SHALL produce no output entry and SHALL go directly from EMIT to NEXT.
- Undefined: an empty tile SHALL emit one entry with out_empty=1, out_last=1, out_light_id=0, then go to NEXT after the handshake.

Structure
REQ-027 Package tile_shading_pkg SHALL hold NTX, NTY, MAX_LIGHTS, LIGHT_ID_W, TILE_IDX_W and the state enum.
REQ-028 The lowest-set-bit search SHALL be sub-module tile_lsb_encoder: input mask, outputs index and any.

Verification
REQ-029 The bench SHALL use NTX=2, NTY=2 and cover the following scenarios:
- Masks {0x5, 0x0, 0x80000000, 0x1}, out_ready=1, macro undefined -> entries (0,0), (0,2 last), (1,empty last), (2,31 last), (3,0 last); then done pulse.
- Same masks, macro defined -> tile 1 produces no entry; 4 entries total; then done.
- Tile 0 mask 0xF, out_ready toggled 1,0,1,0 -> ids 0,1,2,3 with outputs stable during stalls; out_last only on id 3.
- Mask 0xFFFFFFFF, out_ready=1 -> 32 entries on consecutive cycles; ids 0..31.
- rst_n low during EMIT of tile 2 -> all outputs 0, no done; next start re-reads from address 0.
- start pulsed while busy -> ignored; exactly one done pulse per pass.
